rr_arbiter: RTL and testbench

Round-robin arbiter that shares one downstream resource (a priority-encoded datapath port) among N requesters. Each cycle it picks the next requester after the last winner, wrapping modulo N, and holds a registered one-hot grant until the owner releases or the hold limit forces rotation. It sits between the requester array and the shared resource and provides both a one-hot grant and an encoded grant index.

---
 rtl/rr_arbiter.sv | 164 ++++++++++++++++
 tb/tb_rr_arbiter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one registered one-hot grant shared among N requesters.
// The owner keeps the grant until it drops its request or, while others wait,
// until it has held it for HOLD_MAX cycles. The next owner is then the first
// requester found scanning upward from just past the old owner. Handoff takes
// effect on the same edge, with no idle cycle in between.
module rr_arbiter #(
    parameter int N        = 8,
    parameter int IDX_W    = $clog2(N),
    parameter int HOLD_MAX = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_vld
);

    // A HOLD_MAX of 0 means unlimited hold. The counter is then unused, but it
    // is still kept one bit wide.
    localparam int               CNT_W    = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (HOLD_MAX > 0) ? CNT_W'(HOLD_MAX - 1) : '0;
    localparam logic [IDX_W:0]   N_EXT    = (IDX_W + 1)'(N);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state_reg, state_next;
    logic [IDX_W-1:0] ptr_reg, ptr_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [N-1:0]     grant_reg, grant_next;
    logic [IDX_W-1:0] idx_reg, idx_next;
    logic             vld_reg, vld_next;

    // Search inputs and results.
    logic [IDX_W-1:0] scan_base;
    logic [N-1:0]     scan_mask;
    logic             win_found;
    logic [IDX_W-1:0] win_idx;
    logic [N-1:0]     win_onehot;

    // Owner-related terms used while BUSY.
    logic [IDX_W-1:0] owner_next_ptr;
    logic             owner_req;
    logic             others_req;

    assign owner_next_ptr = (idx_reg == LAST_IDX) ? '0 : idx_reg + 1'b1;
    assign owner_req      = |(req & grant_reg);
    assign others_req     = |(req & ~grant_reg);

    // When IDLE, the scan starts at the stored pointer. When BUSY, it starts
    // just past the owner and skips the owner itself. That starting point is
    // exactly the pointer value that a release or a preemption stores.
    assign scan_base = (state_reg == IDLE) ? ptr_reg : owner_next_ptr;
    assign scan_mask = (state_reg == IDLE) ? req : (req & ~grant_reg);

    // First set bit of scan_mask at or after scan_base, wrapping modulo N.
    // The loop walks the offsets from farthest to nearest, so the nearest hit
    // overwrites the others and wins.
    always_comb begin : search
        logic [IDX_W:0] pos;
        win_found = 1'b0;
        win_idx   = '0;
        pos       = '0;
        for (int k = N - 1; k >= 0; k--) begin
            pos = {1'b0, scan_base} + (IDX_W + 1)'(k);
            if (pos >= N_EXT) begin
                pos = pos - N_EXT;
            end
            if (scan_mask[pos[IDX_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = pos[IDX_W-1:0];
            end
        end
    end

    // Decode the winning index into the one-hot grant vector.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_dec
            assign win_onehot[gi] = (win_idx == IDX_W'(gi));
        end
    endgenerate

    // Next-state and next-output logic. By default every register holds its value.
    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        cnt_next   = cnt_reg;
        grant_next = grant_reg;
        idx_next   = idx_reg;
        vld_next   = vld_reg;
        case (state_reg)
            IDLE: begin
                if (win_found) begin
                    grant_next = win_onehot;
                    idx_next   = win_idx;
                    vld_next   = 1'b1;
                    cnt_next   = '0;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (!owner_req) begin
                    // Release. Hand off directly, or drop to IDLE if nobody else wants the resource.
                    ptr_next = owner_next_ptr;
                    cnt_next = '0;
                    if (win_found) begin
                        grant_next = win_onehot;
                        idx_next   = win_idx;
                    end else begin
                        grant_next = '0;
                        idx_next   = '0;
                        vld_next   = 1'b0;
                        state_next = IDLE;
                    end
                end else if ((HOLD_MAX != 0) && (cnt_reg == CNT_LAST)) begin
                    // Hold limit reached. Preempt only if someone else is waiting.
                    cnt_next = '0;
                    if (others_req) begin
                        ptr_next   = owner_next_ptr;
                        grant_next = win_onehot;
                        idx_next   = win_idx;
                    end
                end else begin
                    cnt_next = (HOLD_MAX == 0) ? '0 : cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                grant_next = '0;
                idx_next   = '0;
                vld_next   = 1'b0;
            end
        endcase
    end

    // State and output registers. Reset clears the outputs immediately, even in the middle of a grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            ptr_reg   <= '0;
            cnt_reg   <= '0;
            grant_reg <= '0;
            idx_reg   <= '0;
            vld_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            cnt_reg   <= cnt_next;
            grant_reg <= grant_next;
            idx_reg   <= idx_next;
            vld_reg   <= vld_next;
        end
    end

    assign grant     = grant_reg;
    assign grant_idx = idx_reg;
    assign grant_vld = vld_reg;

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed testbench for rr_arbiter with N=4 and HOLD_MAX=4.
// Inputs change 1 time unit after the rising edge. Outputs are sampled at that same point.
module tb_rr_arbiter;

    localparam int N        = 4;
    localparam int IDX_W    = 2;
    localparam int HOLD_MAX = 4;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic [N-1:0]     req   = '0;
    logic [N-1:0]     grant;
    logic [IDX_W-1:0] grant_idx;
    logic             grant_vld;

    int n_checks = 0;
    int n_fail   = 0;

    rr_arbiter #(
        .N       (N),
        .IDX_W   (IDX_W),
        .HOLD_MAX(HOLD_MAX)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .grant    (grant),
        .grant_idx(grant_idx),
        .grant_vld(grant_vld)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and log the resulting transaction.
    task automatic tick();
        @(posedge clk);
        #1;
        $display("t=%0t req=%b grant=%b idx=%0d vld=%b", $time, req, grant, grant_idx, grant_vld);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = '0;
        @(posedge clk);
        #1;
        n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL reset_grant: got %b expected 0000", grant); end
        n_checks++; if (grant_idx !== 2'd0) begin n_fail++; $display("FAIL reset_idx: got %0d expected 0", grant_idx); end
        n_checks++; if (grant_vld !== 1'b0) begin n_fail++; $display("FAIL reset_vld: got %b expected 0", grant_vld); end
        rst_n = 1'b1;
        req   = 4'b1000;
        tick();
        n_checks++; if (grant !== 4'b1000) begin n_fail++; $display("FAIL pre_reset_grant: got %b expected 1000", grant); end
        // Assert reset between clock edges while the grant is active.
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL async_reset_grant: got %b expected 0000", grant); end
        n_checks++; if (grant_idx !== 2'd0) begin n_fail++; $display("FAIL async_reset_idx: got %0d expected 0", grant_idx); end
        n_checks++; if (grant_vld !== 1'b0) begin n_fail++; $display("FAIL async_reset_vld: got %b expected 0", grant_vld); end
        req = '0;
        #2 rst_n = 1'b1;
        req = 4'b0100;
        tick();
        n_checks++; if (grant !== 4'b0100) begin n_fail++; $display("FAIL post_reset_grant: got %b expected 0100", grant); end
        n_checks++; if (grant_idx !== 2'd2) begin n_fail++; $display("FAIL post_reset_idx: got %0d expected 2", grant_idx); end
        req = '0;
        tick();
        n_checks++; if (grant_vld !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle_vld: got %b expected 0", grant_vld); end
    endtask

    task automatic test_single();
        do_reset();
        req = 4'b0001;
        tick();
        n_checks++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL single_grant: got %b expected 0001", grant); end
        n_checks++; if (grant_idx !== 2'd0) begin n_fail++; $display("FAIL single_idx: got %0d expected 0", grant_idx); end
        n_checks++; if (grant_vld !== 1'b1) begin n_fail++; $display("FAIL single_vld: got %b expected 1", grant_vld); end
        for (int e = 1; e <= 4; e++) begin
            tick();
            n_checks++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL single_hold edge %0d: got %b expected 0001", e, grant); end
        end
        req = '0;
        tick();
        n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL single_release_grant: got %b expected 0000", grant); end
        n_checks++; if (grant_idx !== 2'd0) begin n_fail++; $display("FAIL single_release_idx: got %0d expected 0", grant_idx); end
        n_checks++; if (grant_vld !== 1'b0) begin n_fail++; $display("FAIL single_release_vld: got %b expected 0", grant_vld); end
    endtask

    task automatic test_contention();
        logic [N-1:0]     exp_g;
        logic [IDX_W-1:0] exp_i;
        do_reset();
        req = 4'b1111;
        // Each owner holds for 4 edges. Expected owner after edge e is (e/4) mod 4.
        for (int e = 0; e < 20; e++) begin
            tick();
            exp_i = IDX_W'((e / 4) % 4);
            exp_g = 4'b0001 << exp_i;
            n_checks++; if (grant !== exp_g) begin n_fail++; $display("FAIL contention_grant edge %0d: got %b expected %b", e, grant, exp_g); end
            n_checks++; if (grant_idx !== exp_i) begin n_fail++; $display("FAIL contention_idx edge %0d: got %0d expected %0d", e, grant_idx, exp_i); end
            n_checks++; if (grant_vld !== 1'b1) begin n_fail++; $display("FAIL contention_vld edge %0d: got %b expected 1", e, grant_vld); end
        end
        req = '0;
        tick();
        n_checks++; if (grant_vld !== 1'b0) begin n_fail++; $display("FAIL contention_idle_vld: got %b expected 0", grant_vld); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        req = 4'b1111;
        repeat (9) tick();
        n_checks++; if (grant !== 4'b0100) begin n_fail++; $display("FAIL b2b_owner2: got %b expected 0100", grant); end
        // Owner 2 releases. The grant passes to 3 with no bubble.
        req = 4'b1011;
        tick();
        n_checks++; if (grant !== 4'b1000) begin n_fail++; $display("FAIL b2b_handoff_grant: got %b expected 1000", grant); end
        n_checks++; if (grant_idx !== 2'd3) begin n_fail++; $display("FAIL b2b_handoff_idx: got %0d expected 3", grant_idx); end
        n_checks++; if (grant_vld !== 1'b1) begin n_fail++; $display("FAIL b2b_handoff_vld: got %b expected 1", grant_vld); end
        // Owner 3 releases. The scan wraps to 0, so requester 1 wins ahead of requester 2.
        req = 4'b0110;
        tick();
        n_checks++; if (grant !== 4'b0010) begin n_fail++; $display("FAIL wrap_grant: got %b expected 0010", grant); end
        n_checks++; if (grant_idx !== 2'd1) begin n_fail++; $display("FAIL wrap_idx: got %0d expected 1", grant_idx); end
        req = '0;
        tick();
        n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL b2b_idle_grant: got %b expected 0000", grant); end
    endtask

    task automatic test_sole_holder();
        do_reset();
        req = 4'b0100;
        for (int e = 0; e < 20; e++) begin
            tick();
            n_checks++; if (grant !== 4'b0100) begin n_fail++; $display("FAIL sole_hold edge %0d: got %b expected 0100", e, grant); end
        end
        // Second phase: requester 0 arrives at cycle 10. Owner 2's count is then 1,
        // so requester 0 should preempt on edge 12.
        do_reset();
        req = 4'b0100;
        repeat (10) tick();
        req = 4'b0101;
        tick();
        n_checks++; if (grant !== 4'b0100) begin n_fail++; $display("FAIL sole_late_e10: got %b expected 0100", grant); end
        tick();
        n_checks++; if (grant !== 4'b0100) begin n_fail++; $display("FAIL sole_late_e11: got %b expected 0100", grant); end
        tick();
        n_checks++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL sole_preempt_grant: got %b expected 0001", grant); end
        n_checks++; if (grant_idx !== 2'd0) begin n_fail++; $display("FAIL sole_preempt_idx: got %0d expected 0", grant_idx); end
        repeat (3) tick();
        n_checks++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL sole_new_owner_hold: got %b expected 0001", grant); end
        tick();
        n_checks++; if (grant !== 4'b0100) begin n_fail++; $display("FAIL sole_rotate_back: got %b expected 0100", grant); end
        n_checks++; if (grant_idx !== 2'd2) begin n_fail++; $display("FAIL sole_rotate_back_idx: got %0d expected 2", grant_idx); end
        req = '0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_back_to_back();
        test_sole_holder();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
